sched_issue_queue: RTL and testbench

SCHED_ISSUE_QUEUE -- requirements
Module: sched_issue_queue

---
 rtl/core_pkg.sv | 26 ++
 rtl/iq_age_select.sv | 24 ++
 rtl/sched_issue_queue.sv | 119 +++++++++++
 tb/tb_sched_issue_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared scheduler types: dispatch/issue payload, issue-queue entry, and sizing constants.
package core_pkg;

  localparam int unsigned IQ_DEPTH_DEF = 8;
  localparam int unsigned NUM_PREGS    = 64;
  localparam int unsigned PREG_W       = $clog2(NUM_PREGS);
  localparam int unsigned PC_W         = 32;
  localparam int unsigned IMM_W        = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [PREG_W-1:0] src1_preg;
    logic [PREG_W-1:0] src2_preg;
    logic [PREG_W-1:0] dst_preg;
    logic [IMM_W-1:0]  imm_val;
    logic              instr_valid;
  } sched_pkt_t;

  typedef struct packed {
    sched_pkt_t pkt;
    logic       valid;
    logic       src1_rdy;
    logic       src2_rdy;
  } iq_entry_t;

endpackage

// File: rtl/iq_age_select.sv
// Oldest-ready picker: grants the eligible entry that no other eligible entry is older than.
module iq_age_select #(
  parameter int unsigned DEPTH = 8
) (
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  input  logic [DEPTH-1:0]            elig,
  output logic [DEPTH-1:0]            grant_c
);

  logic [DEPTH-1:0] blk_c;

  // older[j][i] set means entry j was dispatched before entry i
  always_comb begin
    blk_c   = '0;
    grant_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (j != i && elig[j] && older[j][i]) blk_c[i] = 1'b1;
      end
      grant_c[i] = elig[i] && !blk_c[i];
    end
  end

endmodule

// File: rtl/sched_issue_queue.sv
// Out-of-order issue queue with tag wakeup and age-ordered single issue per cycle.
// Define SCHED_SAME_CYCLE_WAKEUP_EN to let a wakeup make an entry selectable in the same cycle.
module sched_issue_queue
  import core_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = IQ_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  sched_pkt_t                    disp_pkt,
  input  logic                          disp_src1_rdy,
  input  logic                          disp_src2_rdy,
  input  logic                          wake_valid,
  input  logic [PREG_W-1:0]             wake_preg,
  input  logic                          flush,
  input  logic                          stall,
  output logic                          fire_valid,
  output sched_pkt_t                    sched_pkt,
  output logic [$clog2(IQ_DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(IQ_DEPTH + 1);

  iq_entry_t                        entries [IQ_DEPTH];
  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] older;
  logic [IQ_DEPTH-1:0]              valid_vec, wake1_c, wake2_c, elig_c, grant_c, alloc_c;
  logic                             accept_c, issue_c, disp_rdy1_c, disp_rdy2_c;
  sched_pkt_t                       sel_pkt_c;

  // Per-entry tag match and eligibility
  always_comb begin
    valid_vec = '0;
    wake1_c   = '0;
    wake2_c   = '0;
    elig_c    = '0;
    for (int i = 0; i < int'(IQ_DEPTH); i++) begin
      valid_vec[i] = entries[i].valid;
      wake1_c[i]   = entries[i].valid && wake_valid && (wake_preg == entries[i].pkt.src1_preg);
      wake2_c[i]   = entries[i].valid && wake_valid && (wake_preg == entries[i].pkt.src2_preg);
`ifdef SCHED_SAME_CYCLE_WAKEUP_EN
      elig_c[i] = entries[i].valid && (entries[i].src1_rdy || wake1_c[i])
                                   && (entries[i].src2_rdy || wake2_c[i]);
`else
      elig_c[i] = entries[i].valid && entries[i].src1_rdy && entries[i].src2_rdy;
`endif
    end
  end

  // Lowest-index free slot, from current state only
  always_comb begin
    alloc_c = '0;
    for (int i = int'(IQ_DEPTH) - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        alloc_c    = '0;
        alloc_c[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_pkt_c = '0;
    for (int i = 0; i < int'(IQ_DEPTH); i++) begin
      if (grant_c[i]) sel_pkt_c = entries[i].pkt;
    end
  end

  assign disp_ready  = ~&valid_vec;
  assign accept_c    = disp_valid && disp_ready;
  assign issue_c     = !stall && |grant_c;
  assign disp_rdy1_c = disp_src1_rdy || (disp_pkt.src1_preg == PREG_W'(0)) ||
                       (wake_valid && wake_preg == disp_pkt.src1_preg);
  assign disp_rdy2_c = disp_src2_rdy || (disp_pkt.src2_preg == PREG_W'(0)) ||
                       (wake_valid && wake_preg == disp_pkt.src2_preg);

  iq_age_select #(.DEPTH(IQ_DEPTH)) u_age_select (
    .older   (older),
    .elig    (elig_c),
    .grant_c (grant_c)
  );

  // Entry, age-matrix and issue-register update; flush outranks everything but reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(IQ_DEPTH); i++) entries[i] <= '0;
      older      <= '0;
      fire_valid <= 1'b0;
      sched_pkt  <= '0;
      occupancy  <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(IQ_DEPTH); i++) entries[i] <= '0;
      older      <= '0;
      fire_valid <= 1'b0;
      occupancy  <= '0;
    end else begin
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
        if (wake1_c[i]) entries[i].src1_rdy <= 1'b1;
        if (wake2_c[i]) entries[i].src2_rdy <= 1'b1;
        if (issue_c && grant_c[i]) entries[i].valid <= 1'b0;
        if (accept_c && alloc_c[i]) begin
          entries[i] <= '{pkt: disp_pkt, valid: 1'b1,
                          src1_rdy: disp_rdy1_c, src2_rdy: disp_rdy2_c};
          // New entry is younger than every entry currently held
          for (int j = 0; j < int'(IQ_DEPTH); j++) begin
            older[i][j] <= 1'b0;
            older[j][i] <= valid_vec[j];
          end
        end
      end
      if (!stall) begin
        fire_valid <= |grant_c;
        if (|grant_c) sched_pkt <= sel_pkt_c;
      end
      occupancy <= occupancy + OCC_W'(accept_c) - OCC_W'(issue_c);
    end
  end

endmodule

// File: tb/tb_sched_issue_queue.sv
// Directed bench for sched_issue_queue (default build, same-cycle wakeup disabled).
module tb_sched_issue_queue;
  import core_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_valid, disp_ready, disp_src1_rdy, disp_src2_rdy;
  sched_pkt_t        disp_pkt, sched_pkt;
  logic              wake_valid, flush, stall, fire_valid;
  logic [PREG_W-1:0] wake_preg;
  logic [OCC_W-1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sched_issue_queue #(.IQ_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_pkt      (disp_pkt),
    .disp_src1_rdy (disp_src1_rdy),
    .disp_src2_rdy (disp_src2_rdy),
    .wake_valid    (wake_valid),
    .wake_preg     (wake_preg),
    .flush         (flush),
    .stall         (stall),
    .fire_valid    (fire_valid),
    .sched_pkt     (sched_pkt),
    .occupancy     (occupancy)
  );

  typedef struct {
    logic        dv;
    logic [31:0] pc;
    int          s1;
    logic        r1;
    logic        wv;
    int          wp;
    logic        fl;
    logic        st;
    logic        efv;
    logic [31:0] epc;
    int          eocc;
    logic        erdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic dv, input logic [31:0] pc, input int s1, input logic r1,
                              input logic wv, input int wp, input logic fl, input logic st,
                              input logic efv, input logic [31:0] epc, input int eocc,
                              input logic erdy);
    vec_t v;
    v.dv = dv; v.pc = pc; v.s1 = s1; v.r1 = r1; v.wv = wv; v.wp = wp; v.fl = fl; v.st = st;
    v.efv = efv; v.epc = epc; v.eocc = eocc; v.erdy = erdy;
    return v;
  endfunction

  function automatic vec_t D(input logic [31:0] pc, input int s1, input logic r1, input logic st,
                             input logic efv, input logic [31:0] epc, input int eocc,
                             input logic erdy);
    return mk(1'b1, pc, s1, r1, 1'b0, 0, 1'b0, st, efv, epc, eocc, erdy);
  endfunction

  function automatic vec_t I(input logic efv, input logic [31:0] epc, input int eocc,
                             input logic erdy);
    return mk(1'b0, 32'h0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, efv, epc, eocc, erdy);
  endfunction

  function automatic vec_t W(input int wp, input logic efv, input logic [31:0] epc,
                             input int eocc, input logic erdy);
    return mk(1'b0, 32'h0, 0, 1'b0, 1'b1, wp, 1'b0, 1'b0, efv, epc, eocc, erdy);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    disp_valid          = v.dv;
    disp_pkt            = '0;
    disp_pkt.pc         = v.pc;
    disp_pkt.src1_preg  = PREG_W'(v.s1);
    disp_pkt.src2_preg  = PREG_W'(6);
    disp_pkt.dst_preg   = PREG_W'(1);
    disp_pkt.instr_valid = 1'b1;
    disp_src1_rdy       = v.r1;
    disp_src2_rdy       = 1'b1;
    wake_valid          = v.wv;
    wake_preg           = PREG_W'(v.wp);
    flush               = v.fl;
    stall               = v.st;
  endtask

  task automatic check_out(input int row, input logic efv, input logic [31:0] epc,
                           input int eocc, input logic erdy);
    chk("fire_valid", row, 32'(fire_valid), 32'(efv));
    chk("sched_pc",   row, sched_pkt.pc,    epc);
    chk("occupancy",  row, 32'(occupancy),  32'(eocc));
    chk("disp_ready", row, 32'(disp_ready), 32'(erdy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single ready op, issue one edge after dispatch
    tbl.push_back(D(32'h1000, 5, 1'b1, 1'b0, 1'b0, 32'h0,    1, 1'b1));
    tbl.push_back(I(1'b1, 32'h1000, 0, 1'b1));
    tbl.push_back(I(1'b0, 32'h1000, 0, 1'b1));
    // Younger ready op bypasses older waiting op; wake frees the older one next cycle
    tbl.push_back(D(32'h2000, 7, 1'b0, 1'b0, 1'b0, 32'h1000, 1, 1'b1));
    tbl.push_back(D(32'h2004, 8, 1'b1, 1'b0, 1'b0, 32'h1000, 2, 1'b1));
    tbl.push_back(W(7, 1'b1, 32'h2004, 1, 1'b1));
    tbl.push_back(I(1'b1, 32'h2000, 0, 1'b1));
    tbl.push_back(I(1'b0, 32'h2000, 0, 1'b1));
    // Age order independent of slot index: 0x3000 sits in slot 1, 0x3004 in slot 0
    tbl.push_back(D(32'h2ff0, 12, 1'b0, 1'b0, 1'b0, 32'h2000, 1, 1'b1));
    tbl.push_back(D(32'h3000, 10, 1'b0, 1'b0, 1'b0, 32'h2000, 2, 1'b1));
    tbl.push_back(W(12, 1'b0, 32'h2000, 2, 1'b1));
    tbl.push_back(I(1'b1, 32'h2ff0, 1, 1'b1));
    tbl.push_back(D(32'h3004, 10, 1'b0, 1'b0, 1'b0, 32'h2ff0, 2, 1'b1));
    tbl.push_back(W(10, 1'b0, 32'h2ff0, 2, 1'b1));
    tbl.push_back(I(1'b1, 32'h3000, 1, 1'b1));
    tbl.push_back(I(1'b1, 32'h3004, 0, 1'b1));
    tbl.push_back(I(1'b0, 32'h3004, 0, 1'b1));
    // Fill, reject when full, drain in order; freed slot not visible same cycle
    for (int k = 0; k < 8; k++)
      tbl.push_back(D(32'h4000 + 32'(4 * k), 9, 1'b0, 1'b0, 1'b0, 32'h3004, k + 1, k < 7));
    tbl.push_back(D(32'h5000, 9, 1'b1, 1'b0, 1'b0, 32'h3004, 8, 1'b0));
    tbl.push_back(W(9, 1'b0, 32'h3004, 8, 1'b0));
    tbl.push_back(D(32'h5004, 9, 1'b1, 1'b0, 1'b1, 32'h4000, 7, 1'b1));
    tbl.push_back(D(32'h5008, 13, 1'b0, 1'b0, 1'b1, 32'h4004, 7, 1'b1));
    for (int m = 0; m < 6; m++)
      tbl.push_back(I(1'b1, 32'h4008 + 32'(4 * m), 6 - m, 1'b1));
    tbl.push_back(I(1'b0, 32'h401c, 1, 1'b1));
    // Stall holds the issue register while dispatch continues
    tbl.push_back(D(32'h6000, 14, 1'b1, 1'b0, 1'b0, 32'h401c, 2, 1'b1));
    tbl.push_back(D(32'h6004, 14, 1'b1, 1'b0, 1'b1, 32'h6000, 2, 1'b1));
    tbl.push_back(D(32'h6008, 14, 1'b1, 1'b1, 1'b1, 32'h6000, 3, 1'b1));
    tbl.push_back(D(32'h600c, 14, 1'b1, 1'b1, 1'b1, 32'h6000, 4, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 32'h6000, 4, 1'b1));
    tbl.push_back(I(1'b1, 32'h6004, 3, 1'b1));
    tbl.push_back(I(1'b1, 32'h6008, 2, 1'b1));
    tbl.push_back(I(1'b1, 32'h600c, 1, 1'b1));
    tbl.push_back(I(1'b0, 32'h600c, 1, 1'b1));
    // Flush with five valid plus a concurrent dispatch
    for (int k = 0; k < 4; k++)
      tbl.push_back(D(32'h7000 + 32'(4 * k), 15, 1'b0, 1'b0, 1'b0, 32'h600c, k + 2, 1'b1));
    tbl.push_back(mk(1'b1, 32'h7010, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 32'h600c, 0, 1'b1));
    tbl.push_back(W(15, 1'b0, 32'h600c, 0, 1'b1));
    tbl.push_back(I(1'b0, 32'h600c, 0, 1'b1));

    rst = 1'b0;
    drive(I(1'b0, 32'h0, 0, 1'b1));
    #12;
    check_out(0, 1'b0, 32'h0, 0, 1'b1);
    chk("reset_pkt", 0, 32'(sched_pkt == '0), 32'd1);
    @(negedge clk) rst = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk) drive(tbl[r]);
      @(posedge clk) #1;
      check_out(r + 1, tbl[r].efv, tbl[r].epc, tbl[r].eocc, tbl[r].erdy);
    end

    // Asynchronous reset mid-operation, with an issued op and a queued op
    @(negedge clk) drive(D(32'h8000, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0));
    @(negedge clk) drive(D(32'h8004, 16, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0));
    @(posedge clk) #1;
    check_out(100, 1'b1, 32'h8000, 1, 1'b1);
    drive(I(1'b0, 32'h0, 0, 1'b1));
    #2 rst = 1'b0;
    #1;
    check_out(101, 1'b0, 32'h0, 0, 1'b1);
    @(negedge clk) rst = 1'b1;
    drive(W(16, 1'b0, 32'h0, 0, 1'b1));
    @(negedge clk) drive(I(1'b0, 32'h0, 0, 1'b1));
    @(posedge clk) #1;
    @(posedge clk) #1;
    check_out(102, 1'b0, 32'h0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
